// File: rtl/enabled_register.sv
// enabled_register
//   WIDTH-bit storage register with a write strobe and asynchronous
//   active-high reset. Intended as one word of a register file: D is the
//   shared write-data bus and EN the decoded per-register write strobe.
//   Positional order D, Q, CLK, EN, RESET keeps older positional
//   instances (D, Q, CLK, EN) valid, with RESET appended.
//
//   Optional build macro: ENABLED_REGISTER_TRACE_EN
//     When defined, every falling CLK edge prints the hierarchical
//     instance name and Q in decimal, binary and hex (simulation only).
//     When undefined, the block is silent. The trace only observes the
//     register, so Q behaves identically either way.
module enabled_register #(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    input  logic             CLK,
    input  logic             EN,
    input  logic             RESET
);

    logic [WIDTH-1:0] r_q;

    // Storage flop: reset has priority, then a full-width write, else hold.
    // An edge that coincides with reset release still sees RESET high and
    // stays in reset. An unknown EN fails the if-test, so Q holds.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_q <= RESET_VALUE;
        end else if (EN) begin
            r_q <= D;
        end
    end

    // Q comes straight from the flop; there is no D->Q combinational path.
    assign Q = r_q;

`ifdef ENABLED_REGISTER_TRACE_EN
    // Falling-edge trace of the stored value; it only reads r_q.
    always @(negedge CLK) begin
        $display("%m Q dec=%0d bin=%b hex=%h", r_q, r_q, r_q);
    end
`endif

endmodule

// File: tb/tb_enabled_register.sv
// Testbench for enabled_register: a vector table through a scoreboard
// queue, plus hand-written reset, mid-cycle and register-bank sequences.
module tb_enabled_register;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] d;
    logic [31:0] q;

    // Eight-word bank sharing one data bus, with a one-hot decoded strobe.
    logic [31:0] d_bank;
    logic [7:0]  en_bank;
    logic [31:0] q_bank [8];

    // Narrow instance with a non-zero reset value.
    logic       en8;
    logic [7:0] d8;
    logic [7:0] q8;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        en;
        logic [31:0] d;
        logic [31:0] exp_q;
    } vec_t;

    vec_t        vecs [10];
    logic [31:0] sb_q [$];

    enabled_register #(.WIDTH(32)) dut (
        .D(d), .Q(q), .CLK(clk), .EN(en), .RESET(rst)
    );

    for (genvar g = 0; g < 8; g++) begin : g_bank
        enabled_register #(.WIDTH(32)) u_reg (
            .D(d_bank), .Q(q_bank[g]), .CLK(clk), .EN(en_bank[g]), .RESET(rst)
        );
    end

    enabled_register #(.WIDTH(8), .RESET_VALUE(8'h5A)) dut8 (
        .D(d8), .Q(q8), .CLK(clk), .EN(en8), .RESET(rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Sample just after the rising edge.
    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp;
        logic [31:0] bank_exp [8];

        rst = 1'b0; en = 1'b0; d = '0;
        d_bank = '0; en_bank = '0; en8 = 1'b0; d8 = '0;

        vecs[0] = '{1'b1, 32'd7,          32'd7};
        vecs[1] = '{1'b0, 32'd9,          32'd7};
        vecs[2] = '{1'b1, 32'hDEAD_BEEF,  32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 32'h1234_5678,  32'hDEAD_BEEF};
        vecs[4] = '{1'b1, 32'h0000_00A5,  32'h0000_00A5};
        vecs[5] = '{1'b0, 32'hFFFF_FFFF,  32'h0000_00A5};
        vecs[6] = '{1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF};
        vecs[7] = '{1'b1, 32'h0000_0000,  32'h0000_0000};
        vecs[8] = '{1'b1, 32'h8000_0001,  32'h8000_0001};
        vecs[9] = '{1'bx, 32'h8000_0001,  32'h8000_0001};

        // Asynchronous reset: Q clears before any clock edge.
        #2;
        rst = 1'b1; en = 1'b1; d = 32'hFFFF_FFFF;
        #1;
        chk("reset_async_before_edge", q, 32'd0);
        chk("reset_value_param", {24'd0, q8}, 32'h5A);
        after_edge();
        chk("reset_hold_cycle1", q, 32'd0);
        after_edge();
        chk("reset_hold_cycle2", q, 32'd0);

        // Release at the falling edge.
        @(negedge clk);
        rst = 1'b0; en = 1'b0;

        // Table-driven vectors through the scoreboard.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            en = vecs[i].en;
            d  = vecs[i].d;
            sb_q.push_back(vecs[i].exp_q);
            after_edge();
            exp = sb_q.pop_front();
            chk($sformatf("vec%0d", i), q, exp);
        end
        en = 1'b0;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        // Write, then change D and glitch EN mid-cycle.
        @(negedge clk);
        en = 1'b1; d = 32'hDEAD_BEEF;
        after_edge();
        chk("write_deadbeef", q, 32'hDEAD_BEEF);
        #1 d = 32'h1234_5678;
        #1 en = 1'b1;
        #1 en = 1'b0;
        #1;
        chk("midcycle_no_transparency", q, 32'hDEAD_BEEF);
        after_edge();
        chk("glitch_en_ignored", q, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("no_change_on_negedge", q, 32'hDEAD_BEEF);

        // Reset mid-cycle discards a fresh write; reset beats EN.
        en = 1'b1; d = 32'h0000_00A5;
        after_edge();
        chk("write_a5", q, 32'h0000_00A5);
        #2 rst = 1'b1;
        #1;
        chk("midcycle_reset_clears", q, 32'd0);
        d = 32'h0000_0077;
        after_edge();
        chk("reset_priority_over_en", q, 32'd0);
        @(negedge clk);
        rst = 1'b0; en = 1'b1; d = 32'd3;
        after_edge();
        chk("first_write_after_release", q, 32'd3);

        // Narrow instance write.
        @(negedge clk);
        en = 1'b0; en8 = 1'b1; d8 = 8'hC3;
        after_edge();
        chk("narrow_write", {24'd0, q8}, 32'hC3);
        en8 = 1'b0;

        // Load each bank word through its decoded address.
        for (int a = 0; a < 8; a++) begin
            @(negedge clk);
            en_bank = 8'(1 << a);
            d_bank  = 32'd100 + 32'(a);
            bank_exp[a] = 32'd100 + 32'(a);
            after_edge();
        end
        @(negedge clk);
        en_bank = '0; d_bank = 32'hFFFF_FFFF;
        after_edge();
        for (int a = 0; a < 8; a++)
            chk($sformatf("bank_load%0d", a), q_bank[a], bank_exp[a]);

        // Address 3'b111 with D=42: only word 7 changes.
        @(negedge clk);
        en_bank = 8'(1 << 3'b111);
        d_bank  = 32'd42;
        bank_exp[7] = 32'd42;
        after_edge();
        en_bank = '0;
        for (int a = 0; a < 8; a++)
            chk($sformatf("bank_addr7_word%0d", a), q_bank[a], bank_exp[a]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/enabled_register.md
ENABLED_REGISTER -- requirements
Module: enabled_register

Interface
REQ-001 Parameter WIDTH, default 32, data width in bits; SHALL accept any value >= 1.
REQ-002 Parameter RESET_VALUE, default 0 (WIDTH bits), value Q takes while RESET is asserted.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 Port CLK, input, 1, sole clock; all state updates on rising edge.
REQ-005 Port RESET, input, 1, asynchronous active-high reset.
REQ-006 Port D, input, WIDTH, write data (register-file write port data).
REQ-007 Port Q, output, WIDTH, stored value, driven directly from the storage flop.
REQ-008 Port EN, input, 1, write enable (decoded per-register write strobe).
REQ-009 Positional port order SHALL be D, Q, CLK, EN, RESET, so that existing positional instances (D, Q, CLK, EN) stay valid with RESET appended.

Function
REQ-010 On a rising CLK edge with RESET low and EN=1, Q SHALL take D; new value visible after the edge (latency 1 cycle).
REQ-011 On a rising CLK edge with RESET low and EN=0, Q SHALL hold its value.
REQ-012 Q SHALL NOT change on a falling CLK edge or on D/EN changes between edges (no transparency, no combinational D->Q path).
REQ-013 EN and D SHALL be sampled only at the rising edge; EN glitches between edges have no effect.
REQ-014 EN=X or Z at an edge SHALL be treated as no write in simulation (Q holds); synthesis treats EN as plain logic.
REQ-015 All WIDTH bits SHALL update together; no partial writes.
REQ-016 Multiple instances sharing D and CLK with one-hot EN SHALL allow exactly one register to change per cycle; with all EN low, no register changes.

Reset
REQ-017 While RESET=1, Q SHALL equal RESET_VALUE immediately, independent of CLK.
REQ-018 RESET SHALL take priority over EN: RESET=1 with EN=1 at an edge leaves Q=RESET_VALUE.
REQ-019 On RESET deassertion, the first rising edge with EN=1 SHALL load D; an edge coincident with deassertion SHALL be treated as still in reset.
REQ-020 A reset asserted mid-cycle after a write SHALL discard the written value.

Configuration
REQ-021 Macro ENABLED_REGISTER_TRACE_EN: when defined, on every falling CLK edge the block SHALL print its hierarchical instance name and Q in decimal, binary and hexadecimal; the print is simulation-only and excluded from synthesis.
REQ-022 When ENABLED_REGISTER_TRACE_EN is undefined, no output SHALL be produced, and function and timing SHALL be identical.

Verification
REQ-023 RESET=1 for 2 cycles, EN=1, D=32'hFFFF_FFFF -> Q=0 throughout; Q goes to 0 asynchronously before any clock edge.
REQ-024 RESET=0, EN=1, D=32'd7 at edge n -> Q=7 after edge n; D=32'd9, EN=0 at edge n+1 -> Q stays 7.
REQ-025 EN=1, D=32'hDEAD_BEEF, then D changes to 32'h1234_5678 mid-cycle with EN=0 before the next edge -> Q=DEAD_BEEF, never 1234_5678.
REQ-026 Q=32'h0000_00A5, assert RESET between edges -> Q=0 within the same cycle; deassert, EN=1, D=32'd3 -> Q=3 after the next edge.
REQ-027 Eight instances sharing D, one-hot EN from 3-bit address 3'b111, D=32'd42 -> only instance 7 reads 42 (decimal 42, binary ...101010, hex 2a), others unchanged.
REQ-028 With ENABLED_REGISTER_TRACE_EN defined, one line per falling edge showing Q in decimal, binary and hex; without the macro, no output and identical Q waveform.
